// File: rtl/dbg_link_if.sv
// Debug-link bundle between the case controller and its NUM_CHNL debug links:
// the broadcast case value, per-channel request/acknowledge and the display/LED
// data each link returns.
interface dbg_link_if #(
    parameter int NUM_CHNL = 2,
    parameter int DIG_SZ   = 4,
    parameter int NUM_DIGS = 2,
    parameter int LED_SZ   = 4
);
    localparam int CSZ = NUM_DIGS * DIG_SZ;

    logic [CSZ-1:0]             o_case;
    logic [NUM_CHNL-1:0]        o_doit;
    logic [NUM_CHNL-1:0]        i_done;
    logic [NUM_CHNL*DIG_SZ-1:0] i_disp0;
    logic [NUM_CHNL*DIG_SZ-1:0] i_disp1;
    logic [NUM_CHNL*LED_SZ-1:0] i_leds;

    // Controller side
    modport master (
        output o_case, o_doit,
        input  i_done, i_disp0, i_disp1, i_leds
    );

    // Debug-link side
    modport slave (
        input  o_case, o_doit,
        output i_done, i_disp0, i_disp1, i_leds
    );
endinterface

// File: rtl/dbg_case_ctrl.sv
// Debug-case controller: three debounced switches edit a multi-digit case
// value, a chord of inc+nxt commits it to every debug link with a doit
// request, acknowledges are collected under a timeout, and one channel's
// returned display/LED data is then muxed onto the board outputs.
module dbg_case_ctrl #(
    parameter int NUM_CHNL = 2,
    parameter int DIG_SZ   = 4,
    parameter int NUM_DIGS = 2,
    parameter int LED_SZ   = 4,
    parameter int TMO_CYC  = 1024,
    parameter int TEST_NUM = 7
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_sw_inc,
    input  logic              i_sw_nxt,
    input  logic              i_sw_chn,
    dbg_link_if.master        link,
    output logic [DIG_SZ-1:0] o_disp0,
    output logic [DIG_SZ-1:0] o_disp1,
    output logic [LED_SZ-1:0] o_leds,
    output logic              o_err
);
    localparam int CSZ   = NUM_DIGS * DIG_SZ;
    localparam int PTR_W = (NUM_DIGS > 1) ? $clog2(NUM_DIGS) : 1;
    localparam int CHN_W = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;
    localparam int CNT_W = $clog2(TMO_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT,
        ST_SHOW
    } state_t;

    state_t              state_q;
    logic                inc_q, nxt_q, chn_sw_q;
    logic                both_q, both_d;
    logic [CSZ-1:0]      buf_q, buf_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CHN_W-1:0]    chn_q, chn_d;
    logic [CSZ-1:0]      case_q;
    logic [NUM_CHNL-1:0] doit_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIG_SZ-1:0]   disp0_q, disp1_q;
    logic [LED_SZ-1:0]   leds_q;

    logic                rel_inc, rel_nxt, rel_chn;
    logic                act_inc, act_nxt, act_commit;
    logic                edit_ok, edit_go;
    logic [NUM_CHNL-1:0] doit_n;
    logic [DIG_SZ-1:0]   sel_d0, sel_d1, chn_d0, chn_d1;
    logic [LED_SZ-1:0]   chn_led;

    // A release is the registered level high while the live level is low.
    // A release with the other switch registered high (held, or released in
    // the same cycle) is a commit chord; otherwise it is a single edit.
    assign rel_inc    = inc_q & ~i_sw_inc;
    assign rel_nxt    = nxt_q & ~i_sw_nxt;
    assign rel_chn    = chn_sw_q & ~i_sw_chn;
    assign act_commit = (rel_inc & nxt_q) | (rel_nxt & inc_q);
    assign act_inc    = rel_inc & ~nxt_q;
    assign act_nxt    = rel_nxt & ~inc_q;
    assign edit_ok    = (state_q == ST_IDLE) || (state_q == ST_SELECT) || (state_q == ST_SHOW);

    // Acks only count against requests still outstanding.
    assign doit_n  = doit_q & ~link.i_done;
    assign chn_d0  = link.i_disp0[chn_q*DIG_SZ +: DIG_SZ];
    assign chn_d1  = link.i_disp1[chn_q*DIG_SZ +: DIG_SZ];
    assign chn_led = link.i_leds[chn_q*LED_SZ +: LED_SZ];

    // Next edit buffer, digit pointer, chord flag and shown channel.
    // The second release of a chord only clears the flag, so finishing a
    // commit never also edits a digit.
    always_comb begin
        buf_d   = buf_q;
        ptr_d   = ptr_q;
        both_d  = both_q;
        chn_d   = chn_q;
        edit_go = (act_inc | act_nxt) & ~both_q & edit_ok;
        if (act_commit) begin
            both_d = 1'b1;
        end else if (act_inc | act_nxt) begin
            both_d = 1'b0;
        end
        if (edit_go && act_inc) begin
            buf_d[ptr_q*DIG_SZ +: DIG_SZ] = buf_q[ptr_q*DIG_SZ +: DIG_SZ] + DIG_SZ'(1);
        end
        if (edit_go && act_nxt) begin
            ptr_d = (ptr_q == PTR_W'(NUM_DIGS - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
        if (rel_chn) begin
            chn_d = (chn_q == CHN_W'(NUM_CHNL - 1)) ? '0 : chn_q + CHN_W'(1);
        end
        sel_d0 = buf_d[ptr_d*DIG_SZ +: DIG_SZ];
        sel_d1 = DIG_SZ'(ptr_d);
    end

    // Control FSM with registered request, error and display outputs.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            inc_q    <= 1'b0;
            nxt_q    <= 1'b0;
            chn_sw_q <= 1'b0;
            both_q   <= 1'b0;
            buf_q    <= '0;
            ptr_q    <= '0;
            chn_q    <= '0;
            case_q   <= '0;
            doit_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            disp0_q  <= DIG_SZ'(TEST_NUM);
            disp1_q  <= DIG_SZ'(TEST_NUM);
            leds_q   <= '0;
        end else begin
            inc_q    <= i_sw_inc;
            nxt_q    <= i_sw_nxt;
            chn_sw_q <= i_sw_chn;
            both_q   <= both_d;
            buf_q    <= buf_d;
            ptr_q    <= ptr_d;
            chn_q    <= chn_d;
            case (state_q)
                ST_IDLE: begin
                    if (edit_go) begin
                        state_q <= ST_SELECT;
                        disp0_q <= sel_d0;
                        disp1_q <= sel_d1;
                        leds_q  <= '0;
                    end
                end
                ST_SELECT: begin
                    disp0_q <= sel_d0;
                    disp1_q <= sel_d1;
                    leds_q  <= '0;
                    if (act_commit) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    case_q  <= buf_q;
                    doit_q  <= '1;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    doit_q <= doit_n;
                    if (doit_n == '0) begin
                        state_q <= ST_SHOW;
                    end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                        doit_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_SHOW;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    disp0_q <= chn_d0;
                    disp1_q <= chn_d1;
                    leds_q  <= chn_led;
                    if (act_commit) begin
                        state_q <= ST_ISSUE;
                    end else if (edit_go) begin
                        state_q <= ST_SELECT;
                        disp0_q <= sel_d0;
                        disp1_q <= sel_d1;
                        leds_q  <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign link.o_case = case_q;
    assign link.o_doit = doit_q;
    assign o_disp0     = disp0_q;
    assign o_disp1     = disp1_q;
    assign o_leds      = leds_q;
    assign o_err       = err_q;
endmodule
